// File: rtl/oled_mode_scheduler.sv
// oled_mode_scheduler: frame-synchronous pixel source selection with black gaps and game init handshake
module oled_mode_scheduler #(
  parameter int BLANK_FRAMES        = 2,
  parameter int INIT_TIMEOUT_FRAMES = 60
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         frame_begin,
  input  logic         req_valid,
  input  logic [2:0]   req_mode,
  output logic         req_ready,
  input  logic         mode_ended,
  input  logic         init_done,
  input  logic [127:0] src_pixels,
  output logic [15:0]  oled_data,
  output logic [2:0]   active_mode,
  output logic         busy,
  output logic         init_start,
  output logic         init_timeout,
  output logic         req_err
);
  typedef enum logic [1:0] {SHOW, DRAIN, BLANK, INIT} state_t;
  state_t      r_state;
  logic [2:0]  r_active, r_target, r_sel;
  logic        r_blank, r_init_start, r_init_timeout, r_req_err;
  logic [7:0]  r_cnt;
  logic [15:0] r_oled;
  logic [7:0]  w_cnt_inc;
  logic        w_target_game, w_active_game;
  assign w_cnt_inc     = (r_cnt == 8'hff) ? r_cnt : r_cnt + 8'd1;
  assign w_target_game = (r_target >= 3'd2) && (r_target <= 3'd4);
  assign w_active_game = (r_active >= 3'd2) && (r_active <= 3'd4);
  assign req_ready     = (r_state == SHOW);
  assign busy          = ~req_ready;
  assign oled_data     = r_oled;
  assign active_mode   = r_active;
  assign init_start    = r_init_start;
  assign init_timeout  = r_init_timeout;
  assign req_err       = r_req_err;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= SHOW;
      r_active       <= '0;
      r_target       <= '0;
      r_sel          <= '0;
      r_blank        <= 1'b0;
      r_cnt          <= '0;
      r_oled         <= '0;
      r_init_start   <= 1'b0;
      r_init_timeout <= 1'b0;
      r_req_err      <= 1'b0;
    end else begin
      r_oled         <= r_blank ? 16'h0000 : src_pixels[16*r_sel +: 16];
      r_init_start   <= 1'b0;
      r_init_timeout <= 1'b0;
      r_req_err      <= 1'b0;
      case (r_state)
        SHOW: begin
          // an accepted external request (legal or not) always beats mode_ended
          if (req_valid) begin
            if (req_mode <= 3'd4) begin
              r_target <= req_mode;
              r_state  <= DRAIN;
            end else r_req_err <= 1'b1;
          end else if (mode_ended && w_active_game) begin
            r_target <= 3'd5;
            r_state  <= DRAIN;
          end
        end
        DRAIN: if (frame_begin) begin
          r_blank <= 1'b1;
          r_cnt   <= 8'd1;
          r_state <= BLANK;
        end
        BLANK: if (frame_begin) begin
          if (r_cnt == BLANK_FRAMES[7:0]) begin
            r_blank <= 1'b0;
            if (w_target_game) begin
              r_sel        <= 3'd7;
              r_init_start <= 1'b1;
              r_cnt        <= '0;
              r_state      <= INIT;
            end else begin
              r_active <= r_target;
              r_sel    <= r_target;
              r_state  <= SHOW;
            end
          end else r_cnt <= w_cnt_inc;
        end
        INIT: if (frame_begin) begin
          if (init_done) begin
            r_active <= r_target;
            r_sel    <= r_target;
            r_state  <= SHOW;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == INIT_TIMEOUT_FRAMES[7:0]) begin
              r_init_timeout <= 1'b1;
              r_active       <= '0;
              r_sel          <= '0;
              r_state        <= SHOW;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: doc/oled_mode_scheduler.md
# oled_mode_scheduler

Frame-synchronous scheduler that owns the OLED pixel stream and decides which of eight 16-bit pixel sources (menu, volume bar, games, game-over, loading) drives the display. It accepts mode-switch requests from the state controller, defers every switch to an OLED frame boundary, inserts a black gap of whole frames, and runs an init handshake with game modes behind a loading screen. It sits between the per-mode renderers and Oled_Display's `pixel_data`, in the `clk_6p25M` domain.

## Interface
- `BLANK_FRAMES`, 2: number of whole black frames inserted on every switch; legal range ≥1.
- `INIT_TIMEOUT_FRAMES`, 60: frames allowed in INIT before abandoning to the menu; legal range ≥1.

- `clk`  in  1  pixel clock (6.25 MHz); the block's only clock.
- `reset`  in  1  synchronous, active-high.
- `frame_begin`  in  1  one-cycle pulse at the start of each OLED frame.
- `req_valid`  in  1  mode-switch request.
- `req_mode`  in  3  requested mode: 0 menu, 1 volume bar, 2 pokemon, 3 fruit, 4 potion; 5–7 illegal as requests.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `mode_ended`  in  1  level/pulse from the active game that it has finished.
- `init_done`  in  1  level from the target game: initialisation complete.
- `src_pixels`  in  128  packed sources; source k at bits [16k+15:16k]; 5 = game-over, 7 = loading, 6 unused.
- `oled_data`  out  16  pixel to Oled_Display.
- `active_mode`  out  3  source currently displayed (valid in SHOW).
- `busy`  out  1  `~req_ready`.
- `init_start`  out  1  one-cycle pulse: target game must begin initialising.
- `init_timeout`  out  1  one-cycle pulse: INIT abandoned.
- `req_err`  out  1  one-cycle pulse: illegal `req_mode` consumed.

## Operation
- States: SHOW, DRAIN, BLANK, INIT. Reset → SHOW, `active_mode`=0, `target`=0, frame counter 0.
- `req_ready` = (state==SHOW), combinational.
- SHOW: accepted request with `req_mode`≤4 → latch `target`, go DRAIN. Same mode as active is a restart (full sequence). `req_mode`≥5 → consumed, `req_err` pulse next cycle, stay SHOW.
- SHOW, `mode_ended`=1 with `active_mode`∈{2,3,4} and no accepted request this cycle → internal request, `target`=5, go DRAIN. External request in the same cycle wins; `mode_ended` is dropped. `mode_ended` in modes 0,1,5 ignored.
- DRAIN: display unchanged; on `frame_begin` → blank on, counter=1, go BLANK.
- BLANK: output black; each `frame_begin` with counter==`BLANK_FRAMES` → if `target`∈{2,3,4}: select source 7, `init_start` pulse, counter=0, go INIT; else `active_mode`=`target`, blank off, go SHOW. Otherwise counter+1.
- INIT: show source 7. On `frame_begin`: if `init_done`=1 → `active_mode`=`target`, go SHOW; else counter+1, and if counter reaches `INIT_TIMEOUT_FRAMES` → `init_timeout` pulse, `active_mode`=0, go SHOW. `init_done` wins over timeout on the same frame. `init_done` is sampled only on `frame_begin`.
- Requests during DRAIN/BLANK/INIT are not accepted (`req_ready`=0); requester holds `req_valid`.
- Counter is 8 bits, saturating; parameters must fit.

## Timing
- `oled_data` registered: cycle n+1 = (blank ? 16'h0000 : `src_pixels` slice of current select at cycle n). Latency 1 cycle.
- Select/blank changes only in the cycle `frame_begin` is high, so a frame never mixes sources (beyond the 1-cycle pipeline aligned to Oled_Display's sample point).
- `init_start`, `init_timeout`, `req_err` registered, high exactly one cycle after the triggering edge.
- `busy` rises the cycle after acceptance.
- Minimum switch time: DRAIN wait + `BLANK_FRAMES` frames (+ ≥1 INIT frame for games).
- Reset outputs: `oled_data`=0, `active_mode`=0, `req_ready`=1 once reset deasserts (0 during reset cycle not required), `busy`=0, pulses 0. Reset mid-sequence aborts to SHOW/menu with no pulses.

## Test plan
- After reset, req `req_mode`=1 → `busy` next cycle; exactly 2 black frames after next `frame_begin`; then `active_mode`=1, `oled_data` equals source 1 one cycle later.
- req mode 2, `init_done` rises mid-frame 3 of INIT → one `init_start` pulse, source 7 shown until next `frame_begin`, then `active_mode`=2.
- req mode 4, `init_done` held 0, `INIT_TIMEOUT_FRAMES`=3 → `init_timeout` pulse after 3rd INIT frame, `active_mode`=0.
- In mode 3, `mode_ended` and req mode 0 same cycle → target 0 (not 5); alone, `mode_ended` → `active_mode`=5 without `init_start`.
- req `req_mode`=6 → `req_err` one cycle, state stays SHOW, `active_mode` unchanged.
- Assert `reset` during BLANK → next cycle `oled_data`=0, `active_mode`=0, `req_ready`=1 after release.
